// File: rtl/reg_status_table.sv
// Tomasulo register result-status (Qi) table.
// Tracks which reservation-station tag will produce each architectural
// register, answers source-readiness lookups at issue, and snoops the CDB to
// drive the register file write port when a broadcast tag still owns a reg.
//
// Interface timing: there is no valid/ready handshake here. issue_valid and
// cdb_valid are single-cycle strobes that are always accepted. Lookups and the
// register-file write port are combinational from the current table state. The
// table and busy_count update on the next rising clock edge.
module reg_status_table #(
  parameter int N_REGISTER = 8,
  parameter int N_NUMBERS  = $clog2(N_REGISTER),
  parameter int N_SIZE     = 16,
  parameter int TAG_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [N_NUMBERS-1:0] issue_rd,
  input  logic                 issue_has_rd,
  input  logic [TAG_W-1:0]     issue_tag,
  input  logic [N_NUMBERS-1:0] rs_num,
  input  logic [N_NUMBERS-1:0] rt_num,
  output logic                 rs_busy,
  output logic [TAG_W-1:0]     rs_tag,
  output logic                 rt_busy,
  output logic [TAG_W-1:0]     rt_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [N_SIZE-1:0]    cdb_data,
  input  logic                 flush,
  output logic [N_SIZE-1:0]    rf_data,
  output logic [N_NUMBERS-1:0] rf_writeNum,
  output logic                 rf_write_flag,
  output logic [N_NUMBERS:0]   busy_count
);

  logic [N_REGISTER-1:0] busy;
  logic [TAG_W-1:0]      tag [N_REGISTER];
  logic [N_REGISTER-1:0] match;
  logic [N_REGISTER-1:0] busy_next;
  logic [N_NUMBERS:0]    count_next;
  logic                  issue_en;

  assign issue_en = issue_valid & issue_has_rd;

  // A register matches only while busy, so a stale (WAW-overwritten) tag never writes.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_REGISTER; i++) begin
      match[i] = cdb_valid & busy[i] & (tag[i] == cdb_tag);
    end
  end

  // Register-file write port: lowest matching index wins if tags were duplicated.
  always_comb begin
    rf_write_flag = 1'b0;
    rf_writeNum   = '0;
    rf_data       = cdb_data;
    for (int i = N_REGISTER - 1; i >= 0; i--) begin
      if (match[i]) begin
        rf_write_flag = 1'b1;
        rf_writeNum   = N_NUMBERS'(i);
      end
    end
    if (reset) begin
      rf_write_flag = 1'b0;
      rf_writeNum   = '0;
    end
  end

  // Source lookups use pre-issue state; a source resolved on the CDB this cycle reads ready.
  always_comb begin
    rs_busy = ~reset & busy[rs_num] & ~(cdb_valid & (cdb_tag == tag[rs_num]));
    rt_busy = ~reset & busy[rt_num] & ~(cdb_valid & (cdb_tag == tag[rt_num]));
    rs_tag  = rs_busy ? tag[rs_num] : '0;
    rt_tag  = rt_busy ? tag[rt_num] : '0;
  end

  // Next busy vector: CDB clears first, then issue sets (issue wins on the same reg).
  always_comb begin
    busy_next = busy & ~match;
    if (issue_en) begin
      busy_next[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
  end

  // Population count of the next busy vector feeds the registered busy_count.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < N_REGISTER; i++) begin
      count_next = count_next + {{N_NUMBERS{1'b0}}, busy_next[i]};
    end
  end

  // Table state and busy_count update; reset > flush > normal.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
      for (int i = 0; i < N_REGISTER; i++) begin
        tag[i] <= '0;
      end
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
      if (issue_en && !flush) begin
        tag[issue_rd] <= issue_tag;
      end
    end
  end

endmodule
